cpu_flow_ctrl: RTL and testbench
================================

// Module: cpu_flow_ctrl
// PURPOSE
// - Control-flow core of the ForthCPU datapath. Bundles three functions:
//   - a 4-phase instruction sequencer;
//   - combinational branch-condition logic steering the program counter's base/offset mux;
//   - an interrupt enable/priority/return state machine.
// - Sits between the jump-group decoder (JRX/JMPX/CC_* controls) and the programCounter (PC_BASEX/PC_OFFSETX/PC_NEXTX/PC_LD_INTn).
// PARAMETERS
// - none (all encodings are fixed constants in the shared package)
// PORTS
// CLK          in   1  system clock, all state on rising edge
// RESET        in   1  asynchronous, active-low reset (0 = in reset)
// CC_SIGN      in   1  ALU sign flag
// CC_CARRY     in   1  ALU carry flag
// CC_ZERO      in   1  ALU zero flag
// CC_PARITY    in   1  ALU parity flag
// CC_SELECTX   in   2  condition select: 00=Z 01=C 10=S 11=P
// CC_INVERTX   in   1  invert selected flag (NZ, NC, ...)
// CC_APPLYX    in   1  conditional jump
// JRX          in   1  1=relative jump, 0=absolute
// JMPX         in   1  unconditional jump
// RETIX        in   1  return-from-interrupt instruction
// EIX          in   1  enable-interrupts instruction
// DIX          in   1  disable-interrupts instruction
// INT0         in   1  interrupt request 0 (level, highest priority)
// INT1         in   1  interrupt request 1 (level)
// FETCH        out  1  phase 0 (one-hot)
// DECODE       out  1  phase 1
// EXECUTE      out  1  phase 2
// COMMIT       out  1  phase 3
// PC_BASEX     out  1  PC adder base: 0=current PC, 1=zero
// PC_OFFSETX   out  1  PC adder offset: 0=constant 2, 1=PC_D
// PC_NEXTX     out  3  PC source: 000 NORMAL, 001 VEC0, 010 VEC1, 011 RETI
// PC_LD_INT0   out  1  load INT0 vector into PC this COMMIT
// PC_LD_INT1   out  1  load INT1 vector into PC this COMMIT
// INT_EN       out  1  interrupt-enable flag
// IN_ISR       out  1  high while an interrupt is in service
// BEHAVIOUR
// Reset (RESET=0, async):
// - FETCH=1, other phases 0; IE=0; FSM=IDLE.
// - PC_NEXTX=000; PC_LD_INTn=0; INT_EN=0; IN_ISR=0.
// Phase sequencer:
// - FETCH->DECODE->EXECUTE->COMMIT->FETCH, one step per rising edge; exactly one phase high.
// - First edge after reset release moves to DECODE. An instruction occupies 4 clocks.
// Branch logic, purely combinational, zero latency:
// - cond = flag[CC_SELECTX] ^ CC_INVERTX; take = JMPX | (CC_APPLYX & cond).
// - take & JRX: BASEX=0, OFFSETX=1 (PC+PC_D). take & !JRX: BASEX=1, OFFSETX=1 (PC_D).
// - Otherwise BASEX=0, OFFSETX=0 (PC+2). Flags with JMPX=CC_APPLYX=0 never branch.
// Interrupt FSM (states IDLE, ISR0, ISR1), updated only at rising edge ending COMMIT:
// - Inputs RETIX/EIX/DIX/INTn are sampled only while COMMIT=1.
// - IE update: DIX clears, else EIX sets; DIX wins if both.
//   EI/DI take effect from the next COMMIT (never the same one).
// - IDLE & IE & INT0: PC_NEXTX=001, PC_LD_INT0=1 during COMMIT.
//   At the edge: IE<=0, ->ISR0.
// - Else IDLE & IE & INT1: PC_NEXTX=010, PC_LD_INT1=1; IE<=0, ->ISR1.
// - ISRn & RETIX: PC_NEXTX=011; IE<=1, ->IDLE.
//   RETI wins over any pending request, which is taken at a later COMMIT.
// - RETIX in IDLE is ignored (PC_NEXTX=000). No nesting: requests in ISRn are held off.
// - PC_NEXTX / PC_LD_INTn are combinational and valid only while COMMIT=1; 000/0 otherwise.
// - INT_EN=IE; IN_ISR = state!=IDLE.
// Reset asserted mid-instruction aborts immediately to the FETCH/IDLE reset values.
// STRUCTURE
// - Shared package: CC_SELECT codes (Z/C/S/P), PC_NEXTX codes, PC_BASE/PC_OFFSET codes, phase enum, IRQ state enum.
// - One sub-module: irq_ctrl_fsm (IE register plus IDLE/ISR0/ISR1 FSM).
// - Phase counter and branch logic live inline in the top.
// TESTING
// - Release reset -> FETCH=1; after 1/2/3/4 edges DECODE/EXECUTE/COMMIT/FETCH respectively.
// - JMPX=1 JRX=1 -> BASEX=0 OFFSETX=1. JMPX=1 JRX=0 -> BASEX=1 OFFSETX=1. NOP -> 0/0.
// - CC_APPLYX=1 SELECT=C INVERT=0: CARRY=0 -> 0/0; CARRY=1 -> 0/1.
//   Same with SELECT=Z INVERT=1: ZERO=1 -> 0/0.
// - EIX at COMMIT, INT0=INT1=1 at the following COMMIT -> PC_NEXTX=001, PC_LD_INT0=1.
//   Afterwards IN_ISR=1, INT_EN=0.
// - In ISR0, RETIX with INT1=1 at COMMIT -> PC_NEXTX=011. Next COMMIT -> PC_NEXTX=010, PC_LD_INT1=1.
// - EIX & DIX together -> INT_EN=0. RESET=0 mid-EXECUTE -> FETCH=1, IN_ISR=0 immediately.

Source files
------------

// File: rtl/cpu_flow_ctrl_pkg.sv
// Shared encodings for the ForthCPU control-flow core: condition selects,
// PC mux codes, instruction phases and interrupt FSM states.
package cpu_flow_ctrl_pkg;

    localparam logic [1:0] CC_SEL_Z = 2'b00;
    localparam logic [1:0] CC_SEL_C = 2'b01;
    localparam logic [1:0] CC_SEL_S = 2'b10;
    localparam logic [1:0] CC_SEL_P = 2'b11;

    localparam logic [2:0] PC_NEXT_NORMAL = 3'b000;
    localparam logic [2:0] PC_NEXT_VEC0   = 3'b001;
    localparam logic [2:0] PC_NEXT_VEC1   = 3'b010;
    localparam logic [2:0] PC_NEXT_RETI   = 3'b011;

    localparam logic PC_BASE_PC     = 1'b0;
    localparam logic PC_BASE_ZERO   = 1'b1;
    localparam logic PC_OFFSET_TWO  = 1'b0;
    localparam logic PC_OFFSET_PCD  = 1'b1;

    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_DECODE  = 2'd1,
        PH_EXECUTE = 2'd2,
        PH_COMMIT  = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_ISR0 = 2'd1,
        IRQ_ISR1 = 2'd2
    } irq_state_e;

    function automatic logic select_flag(input logic [1:0] sel,
                                         input logic zero,
                                         input logic carry,
                                         input logic sign,
                                         input logic parity);
        logic f;
        case (sel)
            CC_SEL_Z: f = zero;
            CC_SEL_C: f = carry;
            CC_SEL_S: f = sign;
            default:  f = parity;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/irq_ctrl_fsm.sv
// Interrupt enable flag and IDLE/ISR0/ISR1 service FSM; all state changes
// happen on the edge that ends COMMIT.
module irq_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       commit,
    input  logic       retix,
    input  logic       eix,
    input  logic       dix,
    input  logic       int0,
    input  logic       int1,
    output logic [2:0] pc_nextx,
    output logic       pc_ld_int0,
    output logic       pc_ld_int1,
    output logic       int_en,
    output logic       in_isr
);
    import cpu_flow_ctrl_pkg::*;

    irq_state_e state_q, state_d;
    logic       ie_q, ie_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
        end
    end

    // Entry and RETI own the IE update; EI/DI only act on an otherwise quiet COMMIT.
    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        pc_nextx   = PC_NEXT_NORMAL;
        pc_ld_int0 = 1'b0;
        pc_ld_int1 = 1'b0;
        if (commit) begin
            if (state_q == IRQ_IDLE && ie_q && int0) begin
                pc_nextx   = PC_NEXT_VEC0;
                pc_ld_int0 = 1'b1;
                ie_d       = 1'b0;
                state_d    = IRQ_ISR0;
            end else if (state_q == IRQ_IDLE && ie_q && int1) begin
                pc_nextx   = PC_NEXT_VEC1;
                pc_ld_int1 = 1'b1;
                ie_d       = 1'b0;
                state_d    = IRQ_ISR1;
            end else if (state_q != IRQ_IDLE && retix) begin
                pc_nextx = PC_NEXT_RETI;
                ie_d     = 1'b1;
                state_d  = IRQ_IDLE;
            end else if (dix) begin
                ie_d = 1'b0;
            end else if (eix) begin
                ie_d = 1'b1;
            end
        end
    end

    assign int_en = ie_q;
    assign in_isr = (state_q != IRQ_IDLE);

endmodule

// File: rtl/cpu_flow_ctrl.sv
// ForthCPU control-flow core: 4-phase sequencer, branch steering of the PC
// adder, and the interrupt controller.
module cpu_flow_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CC_SIGN,
    input  logic       CC_CARRY,
    input  logic       CC_ZERO,
    input  logic       CC_PARITY,
    input  logic [1:0] CC_SELECTX,
    input  logic       CC_INVERTX,
    input  logic       CC_APPLYX,
    input  logic       JRX,
    input  logic       JMPX,
    input  logic       RETIX,
    input  logic       EIX,
    input  logic       DIX,
    input  logic       INT0,
    input  logic       INT1,
    output logic       FETCH,
    output logic       DECODE,
    output logic       EXECUTE,
    output logic       COMMIT,
    output logic       PC_BASEX,
    output logic       PC_OFFSETX,
    output logic [2:0] PC_NEXTX,
    output logic       PC_LD_INT0,
    output logic       PC_LD_INT1,
    output logic       INT_EN,
    output logic       IN_ISR
);
    import cpu_flow_ctrl_pkg::*;

    phase_e phase_q, phase_d;
    logic   cond;
    logic   take;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_q <= PH_FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PH_FETCH;
        case (phase_q)
            PH_FETCH:   phase_d = PH_DECODE;
            PH_DECODE:  phase_d = PH_EXECUTE;
            PH_EXECUTE: phase_d = PH_COMMIT;
            default:    phase_d = PH_FETCH;
        endcase
    end

    assign FETCH   = (phase_q == PH_FETCH);
    assign DECODE  = (phase_q == PH_DECODE);
    assign EXECUTE = (phase_q == PH_EXECUTE);
    assign COMMIT  = (phase_q == PH_COMMIT);

    // Absolute jumps zero the adder base so the sum is just PC_D.
    always_comb begin
        cond       = select_flag(CC_SELECTX, CC_ZERO, CC_CARRY, CC_SIGN, CC_PARITY) ^ CC_INVERTX;
        take       = JMPX | (CC_APPLYX & cond);
        PC_BASEX   = PC_BASE_PC;
        PC_OFFSETX = PC_OFFSET_TWO;
        if (take) begin
            PC_BASEX   = JRX ? PC_BASE_PC : PC_BASE_ZERO;
            PC_OFFSETX = PC_OFFSET_PCD;
        end
    end

    irq_ctrl_fsm u_irq (
        .clk        (CLK),
        .rst_n      (RESET),
        .commit     (COMMIT),
        .retix      (RETIX),
        .eix        (EIX),
        .dix        (DIX),
        .int0       (INT0),
        .int1       (INT1),
        .pc_nextx   (PC_NEXTX),
        .pc_ld_int0 (PC_LD_INT0),
        .pc_ld_int1 (PC_LD_INT1),
        .int_en     (INT_EN),
        .in_isr     (IN_ISR)
    );

endmodule

// File: tb/tb_cpu_flow_ctrl.sv
// Scoreboard bench for cpu_flow_ctrl: the driver pushes model predictions,
// a monitor pops and compares one entry per cycle.
module tb_cpu_flow_ctrl;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       CC_SIGN = 1'b0, CC_CARRY = 1'b0, CC_ZERO = 1'b0, CC_PARITY = 1'b0;
   logic [1:0] CC_SELECTX = 2'b00;
   logic       CC_INVERTX = 1'b0, CC_APPLYX = 1'b0, JRX = 1'b0, JMPX = 1'b0;
   logic       RETIX = 1'b0, EIX = 1'b0, DIX = 1'b0, INT0 = 1'b0, INT1 = 1'b0;
   logic       FETCH, DECODE, EXECUTE, COMMIT, PC_BASEX, PC_OFFSETX;
   logic [2:0] PC_NEXTX;
   logic       PC_LD_INT0, PC_LD_INT1, INT_EN, IN_ISR;

   always #5 CLK = ~CLK;

   cpu_flow_ctrl dut (
      .CLK(CLK), .RESET(RESET),
      .CC_SIGN(CC_SIGN), .CC_CARRY(CC_CARRY), .CC_ZERO(CC_ZERO), .CC_PARITY(CC_PARITY),
      .CC_SELECTX(CC_SELECTX), .CC_INVERTX(CC_INVERTX), .CC_APPLYX(CC_APPLYX),
      .JRX(JRX), .JMPX(JMPX), .RETIX(RETIX), .EIX(EIX), .DIX(DIX),
      .INT0(INT0), .INT1(INT1),
      .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
      .PC_BASEX(PC_BASEX), .PC_OFFSETX(PC_OFFSETX), .PC_NEXTX(PC_NEXTX),
      .PC_LD_INT0(PC_LD_INT0), .PC_LD_INT1(PC_LD_INT1),
      .INT_EN(INT_EN), .IN_ISR(IN_ISR)
   );

   typedef struct packed {
      logic       rstN;
      logic       zero, carry, sign, parity;
      logic [1:0] sel;
      logic       inv, apply, jr, jmp, reti, ei, di, i0, i1;
   } stim_t;

   typedef struct packed {
      logic [3:0] phases;
      logic       baseX, offX;
      logic [2:0] nextX;
      logic       ld0, ld1, ie, isr;
   } exp_t;

   exp_t expQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   // Reference model: instruction phase as a count mod 4, IE bit, and which ISR is active
   int   mPhase = 0;
   bit   mIe = 1'b0;
   int   mIsr = 0;

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      s.rstN = 1'b1;
      return s;
   endfunction

   // Drives one cycle of stimulus and predicts the outputs visible during that cycle
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      logic flagArr [0:3];
      logic take;
      bit   nIe;
      int   nIsr;
      @(negedge CLK);
      RESET = s.rstN; CC_ZERO = s.zero; CC_CARRY = s.carry; CC_SIGN = s.sign;
      CC_PARITY = s.parity; CC_SELECTX = s.sel; CC_INVERTX = s.inv; CC_APPLYX = s.apply;
      JRX = s.jr; JMPX = s.jmp; RETIX = s.reti; EIX = s.ei; DIX = s.di;
      INT0 = s.i0; INT1 = s.i1;
      if (!s.rstN) begin
         mPhase = 0; mIe = 1'b0; mIsr = 0;
      end
      flagArr[0] = s.zero; flagArr[1] = s.carry; flagArr[2] = s.sign; flagArr[3] = s.parity;
      take = s.jmp | (s.apply & (flagArr[s.sel] ^ s.inv));
      e = '0;
      e.phases = 4'b0001 << mPhase;
      e.offX = take;
      e.baseX = take & !s.jr;
      e.ie = mIe;
      e.isr = (mIsr != 0);
      nIe = mIe;
      nIsr = mIsr;
      if (mPhase == 3) begin
         if (mIsr == 0 && mIe && s.i0) begin
            e.nextX = 3'd1; e.ld0 = 1'b1; nIe = 1'b0; nIsr = 1;
         end else if (mIsr == 0 && mIe && s.i1) begin
            e.nextX = 3'd2; e.ld1 = 1'b1; nIe = 1'b0; nIsr = 2;
         end else if (mIsr != 0 && s.reti) begin
            e.nextX = 3'd3; nIe = 1'b1; nIsr = 0;
         end else if (s.di) begin
            nIe = 1'b0;
         end else if (s.ei) begin
            nIe = 1'b1;
         end
      end
      expQ.push_back(e);
      if (s.rstN) begin
         mPhase = (mPhase + 1) % 4;
         mIe = nIe;
         mIsr = nIsr;
      end
   endtask

   // Idles until the model reaches phase p, then issues s in that phase
   task automatic runToPhase(input int p, input stim_t s);
      int guard;
      guard = 0;
      while (mPhase != p && guard < 8) begin
         applyStimulus(nop());
         guard++;
      end
      applyStimulus(s);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT against the oldest prediction once per cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("phase", {COMMIT, EXECUTE, DECODE, FETCH}, e.phases);
            checkOutput("pc_basex", {3'b000, PC_BASEX}, {3'b000, e.baseX});
            checkOutput("pc_offsetx", {3'b000, PC_OFFSETX}, {3'b000, e.offX});
            checkOutput("pc_nextx", {1'b0, PC_NEXTX}, {1'b0, e.nextX});
            checkOutput("pc_ld_int0", {3'b000, PC_LD_INT0}, {3'b000, e.ld0});
            checkOutput("pc_ld_int1", {3'b000, PC_LD_INT1}, {3'b000, e.ld1});
            checkOutput("int_en", {3'b000, INT_EN}, {3'b000, e.ie});
            checkOutput("in_isr", {3'b000, IN_ISR}, {3'b000, e.isr});
         end
      end
   end

   initial begin
      stim_t s;
      s = nop(); s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      repeat (5) applyStimulus(nop());

      s = nop(); s.jmp = 1'b1; s.jr = 1'b1; applyStimulus(s);
      s = nop(); s.jmp = 1'b1; s.jr = 1'b0; applyStimulus(s);
      s = nop(); s.apply = 1'b1; s.sel = 2'b01; s.carry = 1'b0; applyStimulus(s);
      s.carry = 1'b1; s.jr = 1'b1; applyStimulus(s);
      s = nop(); s.apply = 1'b1; s.sel = 2'b00; s.inv = 1'b1; s.zero = 1'b1; applyStimulus(s);
      s = nop(); s.zero = 1'b1; s.carry = 1'b1; s.sign = 1'b1; s.parity = 1'b1; applyStimulus(s);

      s = nop(); s.ei = 1'b1; runToPhase(3, s);
      s = nop(); s.i0 = 1'b1; s.i1 = 1'b1; runToPhase(3, s);
      applyStimulus(nop());
      s = nop(); s.reti = 1'b1; s.i1 = 1'b1; runToPhase(3, s);
      s = nop(); s.i1 = 1'b1; runToPhase(3, s);
      s = nop(); s.reti = 1'b1; runToPhase(3, s);
      s = nop(); s.reti = 1'b1; runToPhase(3, s);
      s = nop(); s.ei = 1'b1; s.di = 1'b1; runToPhase(3, s);
      applyStimulus(nop());

      s = nop(); s.ei = 1'b1; runToPhase(3, s);
      s = nop(); s.i0 = 1'b1; runToPhase(3, s);
      s = nop(); s.rstN = 1'b0; runToPhase(2, s);
      applyStimulus(nop());

      repeat (3000) begin
         s.rstN   = ($urandom_range(0, 199) != 0);
         s.zero   = 1'($urandom_range(0, 1));
         s.carry  = 1'($urandom_range(0, 1));
         s.sign   = 1'($urandom_range(0, 1));
         s.parity = 1'($urandom_range(0, 1));
         s.sel    = 2'($urandom_range(0, 3));
         s.inv    = 1'($urandom_range(0, 1));
         s.apply  = 1'($urandom_range(0, 1));
         s.jr     = 1'($urandom_range(0, 1));
         s.jmp    = ($urandom_range(0, 3) == 0);
         s.reti   = ($urandom_range(0, 3) == 0);
         s.ei     = ($urandom_range(0, 3) == 0);
         s.di     = ($urandom_range(0, 7) == 0);
         s.i0     = ($urandom_range(0, 2) == 0);
         s.i1     = ($urandom_range(0, 2) == 0);
         applyStimulus(s);
      end

      @(negedge CLK);
      #5;
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
